// File: rtl/ss_pkg.sv
// rtl/ss_pkg.sv - shared constants for the scatter-gather read-data path
package ss_pkg;

    localparam int SS_FIFO_AW   = 4;
    localparam int SS_FIFO_DW   = 64;
    localparam int SS_FIFO_HALF = 8;

endpackage

// File: rtl/ss_fifo_ram.sv
// rtl/ss_fifo_ram.sv - simple dual-port RAM, synchronous write, asynchronous read
module ss_fifo_ram
    import ss_pkg::*;
#(
    parameter int AW = SS_FIFO_AW,
    parameter int DW = SS_FIFO_DW
) (
    input  logic          wb_clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    // Contents are deliberately not reset so this maps onto distributed RAM.
    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge wb_clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ss_rd_fifo.sv
// rtl/ss_rd_fifo.sv - FWFT read-data buffer between the SG reader and the copy engine
module ss_rd_fifo
    import ss_pkg::*;
#(
    parameter int AW = SS_FIFO_AW
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cap_en,
    input  logic          wbs_ack,
    input  logic [31:0]   wbs_dat_o,
    input  logic [31:0]   wbs_dat64_o,
    input  logic          flush,
    input  logic          rd_en,
    output logic [63:0]   rd_dat,
    output logic          rd_valid,
    output logic          fifo_full,
    output logic          fifo_half_empty,
    output logic [AW:0]   fifo_level,
    output logic          ovf_err,
    output logic          udf_err
);

    localparam int DEPTH = 2**AW;
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_HALF = (AW+1)'(DEPTH / 2);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic          push_req;
    logic          pop_ok;
    logic          push_ok;
    logic          ram_we;
    logic [63:0]   ram_wdata;

    assign push_req  = cap_en & wbs_ack;
    assign pop_ok    = rd_en & (level_q != '0);
    // A full FIFO still takes a beat when the head leaves in the same cycle.
    assign push_ok   = push_req & ((level_q < LVL_FULL) | pop_ok);
    assign ram_we    = push_ok & ~flush;
    assign ram_wdata = {wbs_dat64_o, wbs_dat_o};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level_d = level_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                level_d = level_q - 1'b1;
            end
            if (push_req && !push_ok) begin
                ovf_d = 1'b1;
            end
            if (rd_en && (level_q == '0)) begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    ss_fifo_ram #(
        .AW (AW),
        .DW (64)
    ) u_ram (
        .wb_clk_i (wb_clk_i),
        .we_i     (ram_we),
        .waddr_i  (wr_ptr_q),
        .wdata_i  (ram_wdata),
        .raddr_i  (rd_ptr_q),
        .rdata_o  (rd_dat)
    );

    assign fifo_level      = level_q;
    assign rd_valid        = (level_q != '0);
    assign fifo_full       = (level_q == LVL_FULL);
    assign fifo_half_empty = (level_q <= LVL_HALF);
    assign ovf_err         = ovf_q;
    assign udf_err         = udf_q;

endmodule

// File: tb/tb_ss_rd_fifo.sv
// tb/tb_ss_rd_fifo.sv - directed self-checking bench for ss_rd_fifo
module tb_ss_rd_fifo;
    import ss_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cap_en, wbs_ack, flush, rd_en;
    logic [31:0] dat_lo, dat_hi;
    logic [63:0] rd_dat;
    logic        rd_valid, fifo_full, fifo_half_empty, ovf_err, udf_err;
    logic [4:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ss_rd_fifo dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .cap_en          (cap_en),
        .wbs_ack         (wbs_ack),
        .wbs_dat_o       (dat_lo),
        .wbs_dat64_o     (dat_hi),
        .flush           (flush),
        .rd_en           (rd_en),
        .rd_dat          (rd_dat),
        .rd_valid        (rd_valid),
        .fifo_full       (fifo_full),
        .fifo_half_empty (fifo_half_empty),
        .fifo_level      (fifo_level),
        .ovf_err         (ovf_err),
        .udf_err         (udf_err)
    );

    function automatic logic [63:0] beat(input int i);
        return {32'hB000_0000 + 32'(i), 32'hC000_0000 + 32'(i)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and return 1 time unit after the edge.
    task automatic cyc(input logic cap, input logic ack, input logic [63:0] d,
                       input logic rd, input logic fl);
        cap_en  = cap;
        wbs_ack = ack;
        dat_hi  = d[63:32];
        dat_lo  = d[31:0];
        rd_en   = rd;
        flush   = fl;
        @(posedge clk);
        #1;
        cap_en  = 1'b0;
        wbs_ack = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cap_en = 0; wbs_ack = 0; flush = 0; rd_en = 0; dat_lo = 0; dat_hi = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 0, 64'h0, 0, 0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_half", 64'(fifo_half_empty), 64'd1);
        chk("rst_full", 64'(fifo_full), 64'd0);
        chk("rst_ovf", 64'(ovf_err), 64'd0);
        chk("rst_udf", 64'(udf_err), 64'd0);

        // Basic push/pop
        cyc(1, 1, 64'h11111111_A0000000, 0, 0);
        chk("b_lvl1", 64'(fifo_level), 64'd1);
        chk("b_valid1", 64'(rd_valid), 64'd1);
        chk("b_head1", rd_dat, 64'h11111111_A0000000);
        cyc(1, 1, 64'h22222222_A0000001, 0, 0);
        cyc(1, 1, 64'h33333333_A0000002, 0, 0);
        chk("b_lvl3", 64'(fifo_level), 64'd3);
        chk("b_pop0", rd_dat, 64'h11111111_A0000000);
        cyc(0, 0, 64'h0, 1, 0);
        chk("b_pop1", rd_dat, 64'h22222222_A0000001);
        chk("b_lvl2", 64'(fifo_level), 64'd2);
        cyc(0, 0, 64'h0, 1, 0);
        chk("b_pop2", rd_dat, 64'h33333333_A0000002);
        cyc(0, 0, 64'h0, 1, 0);
        chk("b_lvl0", 64'(fifo_level), 64'd0);
        chk("b_valid0", 64'(rd_valid), 64'd0);
        chk("b_udf0", 64'(udf_err), 64'd0);

        // Fill to full, then overflow
        for (int i = 0; i < 16; i++) begin
            cyc(1, 1, beat(i), 0, 0);
            if (i == 7) chk("f_half8", 64'(fifo_half_empty), 64'd1);
            if (i == 8) chk("f_half9", 64'(fifo_half_empty), 64'd0);
            if (i == 14) chk("f_full15", 64'(fifo_full), 64'd0);
        end
        chk("f_full16", 64'(fifo_full), 64'd1);
        chk("f_lvl16", 64'(fifo_level), 64'd16);
        cyc(1, 1, beat(99), 0, 0);
        chk("o_lvl", 64'(fifo_level), 64'd16);
        chk("o_ovf", 64'(ovf_err), 64'd1);
        chk("o_head", rd_dat, beat(0));

        // Flush clears the sticky overflow
        cyc(0, 0, 64'h0, 0, 1);
        chk("fl_lvl", 64'(fifo_level), 64'd0);
        chk("fl_ovf", 64'(ovf_err), 64'd0);

        // Refill, then push and pop together while full across the pointer wrap
        for (int i = 0; i < 16; i++) cyc(1, 1, beat(i), 0, 0);
        cyc(1, 1, beat(16), 1, 0);
        cyc(1, 1, beat(17), 1, 0);
        chk("w_lvl", 64'(fifo_level), 64'd16);
        chk("w_ovf", 64'(ovf_err), 64'd0);
        for (int i = 2; i < 18; i++) begin
            chk($sformatf("w_ord%0d", i), rd_dat, beat(i));
            cyc(0, 0, 64'h0, 1, 0);
        end
        chk("w_lvl0", 64'(fifo_level), 64'd0);
        chk("w_udf", 64'(udf_err), 64'd0);

        // Empty edge cases
        cyc(0, 0, 64'h0, 1, 0);
        chk("e_udf", 64'(udf_err), 64'd1);
        chk("e_lvl", 64'(fifo_level), 64'd0);
        cyc(0, 0, 64'h0, 0, 1);
        chk("e_udfclr", 64'(udf_err), 64'd0);
        cyc(1, 1, beat(40), 1, 0);
        chk("e_pp_lvl", 64'(fifo_level), 64'd1);
        chk("e_pp_udf", 64'(udf_err), 64'd1);
        chk("e_pp_head", rd_dat, beat(40));

        // Flush at level 10 beats a simultaneous push and pop
        for (int i = 41; i < 50; i++) cyc(1, 1, beat(i), 0, 0);
        chk("x_lvl10", 64'(fifo_level), 64'd10);
        chk("x_udf", 64'(udf_err), 64'd1);
        cyc(1, 1, beat(60), 1, 1);
        chk("x_lvl0", 64'(fifo_level), 64'd0);
        chk("x_udf0", 64'(udf_err), 64'd0);
        chk("x_ovf0", 64'(ovf_err), 64'd0);
        chk("x_half", 64'(fifo_half_empty), 64'd1);
        chk("x_valid", 64'(rd_valid), 64'd0);

        // Ack outside the buffer phase is ignored
        cyc(0, 1, beat(70), 0, 0);
        chk("c_lvl", 64'(fifo_level), 64'd0);
        chk("c_valid", 64'(rd_valid), 64'd0);
        cyc(1, 1, beat(71), 0, 0);
        chk("c_head", rd_dat, beat(71));

        // Asynchronous reset mid-burst
        cyc(1, 1, beat(72), 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("r_lvl", 64'(fifo_level), 64'd0);
        chk("r_valid", 64'(rd_valid), 64'd0);
        #1;
        rst = 1'b0;
        cyc(1, 1, beat(73), 0, 0);
        chk("r_lvl1", 64'(fifo_level), 64'd1);
        chk("r_head", rd_dat, beat(73));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
